// File: rtl/adsr_sequencer.sv
// adsr_sequencer
//   Note-driven controller for the 16-bit ADSR amplitude datapath. It turns
//   note_on/note_off events and the 48 kHz sample strobe into a phase code and
//   a step index. The downstream gain stage uses these two values to select
//   its envelope shift-add coefficients.
//
//   Ports
//     clk             system clock
//     reset           asynchronous reset, active low
//     in_ready        one-cycle sample strobe (48 kHz)
//     note_on         one-cycle pulse: start or retrigger from ATTACK step 0
//     note_off        one-cycle pulse: enter RELEASE (ATTACK/DECAY/SUSTAIN only)
//     cfg_load        one-cycle pulse: latch the three cfg_*_len values
//     cfg_attack_len  samples per attack step
//     cfg_decay_len   samples per decay step
//     cfg_release_len samples per release step
//     phase           0=IDLE 1=ATTACK 2=DECAY 3=SUSTAIN 4=RELEASE
//     step            step index within the current timed phase
//     active          high whenever phase != IDLE
//     done            one-cycle pulse on RELEASE expiry into IDLE
//     cfg_err         one-cycle pulse when a cfg_load is rejected
module adsr_sequencer #(
  parameter int STEP_SAMPLES = 480,
  parameter int NUM_STEPS    = 10,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_ready,
  input  logic                 note_on,
  input  logic                 note_off,
  input  logic                 cfg_load,
  input  logic [LEN_WIDTH-1:0] cfg_attack_len,
  input  logic [LEN_WIDTH-1:0] cfg_decay_len,
  input  logic [LEN_WIDTH-1:0] cfg_release_len,
  output logic [2:0]           phase,
  output logic [3:0]           step,
  output logic                 active,
  output logic                 done,
  output logic                 cfg_err
);

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_ATTACK  = 3'd1,
    PH_DECAY   = 3'd2,
    PH_SUSTAIN = 3'd3,
    PH_RELEASE = 3'd4
  } phase_t;

  localparam logic [3:0]           STEP_LAST   = 4'(NUM_STEPS - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_RESET   = LEN_WIDTH'(STEP_SAMPLES);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE     = LEN_WIDTH'(1);

  phase_t               phase_q, phase_d;
  logic [3:0]           step_q, step_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] attack_len_q, attack_len_d;
  logic [LEN_WIDTH-1:0] decay_len_q, decay_len_d;
  logic [LEN_WIDTH-1:0] release_len_q, release_len_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 cfg_err_q, cfg_err_d;

  logic [LEN_WIDTH-1:0] cur_len;
  logic [LEN_WIDTH-1:0] cnt_last;
  logic                 timed;

  // Length register of the phase being timed; a stored 0 behaves as 1 so the
  // terminal count never wraps to all-ones.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cur_len = LEN_ONE;
    timed   = 1'b0;
    unique case (phase_q)
      PH_ATTACK:  begin cur_len = attack_len_q;  timed = 1'b1; end
      PH_DECAY:   begin cur_len = decay_len_q;   timed = 1'b1; end
      PH_RELEASE: begin cur_len = release_len_q; timed = 1'b1; end
      default:    ;
    endcase
    if (cur_len == '0) cur_len = LEN_ONE;
    cnt_last = cur_len - LEN_ONE;
  end

  // Next-state logic. Priority: note_on > note_off > in_ready; a tick that
  // coincides with an accepted event is dropped.
  always_comb begin
    phase_d       = phase_q;
    step_d        = step_q;
    cnt_d         = cnt_q;
    attack_len_d  = attack_len_q;
    decay_len_d   = decay_len_q;
    release_len_d = release_len_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;

    if (note_on) begin
      phase_d = PH_ATTACK;
      step_d  = '0;
      cnt_d   = '0;
    end else if (note_off && (phase_q == PH_ATTACK || phase_q == PH_DECAY ||
                              phase_q == PH_SUSTAIN)) begin
      phase_d = PH_RELEASE;
      step_d  = '0;
      cnt_d   = '0;
    end else if (in_ready && timed) begin
      if (cnt_q != cnt_last) begin
        cnt_d = cnt_q + LEN_ONE;
      end else begin
        cnt_d = '0;
        if (step_q != STEP_LAST) begin
          step_d = step_q + 4'd1;
        end else begin
          step_d = '0;
          unique case (phase_q)
            PH_ATTACK:  phase_d = PH_DECAY;
            PH_DECAY:   phase_d = PH_SUSTAIN;
            PH_RELEASE: begin
              phase_d = PH_IDLE;
              done_d  = 1'b1;
            end
            default:    ;
          endcase
        end
      end
    end

    // Lengths only change while idle so a running envelope never sees a
    // half-applied configuration; a note_on in the same cycle wins.
    if (cfg_load) begin
      if (phase_q == PH_IDLE && !note_on) begin
        attack_len_d  = cfg_attack_len;
        decay_len_d   = cfg_decay_len;
        release_len_d = cfg_release_len;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    active_d = (phase_d != PH_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q       <= PH_IDLE;
      step_q        <= '0;
      cnt_q         <= '0;
      attack_len_q  <= LEN_RESET;
      decay_len_q   <= LEN_RESET;
      release_len_q <= LEN_RESET;
      active_q      <= 1'b0;
      done_q        <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      step_q        <= step_d;
      cnt_q         <= cnt_d;
      attack_len_q  <= attack_len_d;
      decay_len_q   <= decay_len_d;
      release_len_q <= release_len_d;
      active_q      <= active_d;
      done_q        <= done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign phase   = phase_q;
  assign step    = step_q;
  assign active  = active_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: doc/adsr_sequencer.md
Name: adsr_sequencer

Overview:
- Gate-driven controller that sequences the 16-bit ADSR amplitude datapath.
- Converts note_on/note_off events and the 48 kHz codec sample strobe into a phase code and a step index (0..9). The downstream gain stage uses these two values to select the envelope shift-add coefficients.
- Replaces free-running phase cycling with note-driven sequencing: sustain holds until release, retrigger is supported, and the step length of each timed phase is runtime-configurable.

Parameters:
- STEP_SAMPLES, 480, reset/default sample ticks per step for the attack, decay and release lengths.
- NUM_STEPS, 10, steps per timed phase; the step index runs 0..NUM_STEPS-1.
- LEN_WIDTH, 16, width of the step-length registers and of the sample counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_ready  in  1  one-cycle sample strobe, 48 kHz.
- note_on  in  1  one-cycle pulse; start or retrigger the envelope.
- note_off  in  1  one-cycle pulse; begin release.
- cfg_load  in  1  one-cycle pulse; load the three cfg_*_len values.
- cfg_attack_len  in  LEN_WIDTH  samples per attack step.
- cfg_decay_len  in  LEN_WIDTH  samples per decay step.
- cfg_release_len  in  LEN_WIDTH  samples per release step.
- phase  out  3  0=IDLE, 1=ATTACK, 2=DECAY, 3=SUSTAIN, 4=RELEASE.
- step  out  4  current step index within the phase.
- active  out  1  high when phase != IDLE.
- done  out  1  one-cycle pulse on the RELEASE->IDLE transition.
- cfg_err  out  1  one-cycle pulse when cfg_load is rejected.

Behaviour:
- Reset (reset=0, asynchronous):
  - phase=IDLE, step=0, sample counter=0, active=0, done=0, cfg_err=0.
  - All three length registers = STEP_SAMPLES.
- Registers: all state updates on the rising edge of clk; every output is registered.
- Timed phases (ATTACK, DECAY, RELEASE), on each in_ready:
  - If cnt != len-1: cnt++.
  - Else: cnt<=0 and the step advances.
  - If the step advances from NUM_STEPS-1: step<=0 and the phase advances ATTACK->DECAY->SUSTAIN, or RELEASE->IDLE.
  - len is the length register of the current phase; a stored length of 0 is treated as 1.
  - Each timed phase therefore lasts exactly len*NUM_STEPS in_ready ticks.
- SUSTAIN: step=0 and cnt=0 are held indefinitely; in_ready is ignored.
- IDLE: in_ready is ignored; step=0.
- note_on, in any phase: next cycle phase=ATTACK, step=0, cnt=0 (retrigger restarts from attack step 0).
- note_off:
  - In ATTACK, DECAY or SUSTAIN: next cycle phase=RELEASE, step=0, cnt=0.
  - In IDLE or RELEASE: ignored.
- Priority in a single cycle: note_on > note_off > in_ready. A tick coinciding with an accepted event is discarded and not counted in the new phase.
- done:
  - Asserted in the same cycle that phase becomes IDLE from RELEASE expiry.
  - Never asserted on reset.
  - Never asserted when note_on preempts RELEASE.
- cfg_load:
  - Accepted only when phase=IDLE and note_on=0 in that cycle. All three lengths latch together and take effect on the next note.
  - Otherwise it is rejected: the lengths are unchanged and cfg_err pulses the next cycle.
- No event is queued; pulses arriving while ignored are lost.
- Widths: cnt and the lengths are LEN_WIDTH bits, with an unsigned compare against len-1. The step compare uses NUM_STEPS-1, which must fit in 4 bits.

Test Plan:
- Reset, then cfg_load with all lengths=3, then note_on, then 30 in_ready ticks:
  - Step increments every 3 ticks, 0..9.
  - phase=DECAY exactly after tick 30.
  - A further 30 ticks -> phase=SUSTAIN, step=0.
  - 100 more ticks -> phase stays SUSTAIN.
- From SUSTAIN, note_off then 30 ticks (release_len=3):
  - phase=RELEASE through tick 29.
  - On tick 30: phase=IDLE, done=1 for exactly one cycle, active=0.
- Retrigger: in ATTACK at step 5, or in RELEASE at step 4, pulse note_on:
  - Next cycle phase=ATTACK, step=0, cnt=0.
  - No done pulse.
- Simultaneous events: note_on, note_off and in_ready in one cycle while in DECAY:
  - Result is ATTACK, step 0, cnt 0.
  - note_off alone in IDLE -> no change.
- Config rules:
  - cfg_load with lengths 0/5/7 in IDLE: attack steps last 1 tick each, decay steps 5 ticks each.
  - cfg_load during SUSTAIN: cfg_err pulses and the lengths are unchanged.
- Asynchronous reset: drop reset mid-DECAY, between clock edges:
  - Outputs go to IDLE/0 immediately.
  - After release of reset, note_on uses lengths of 480 (480 ticks per step).
